// File: rtl/unified_mem_arbiter.sv
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported, fixed-latency memory between the
//            instruction-fetch port and the data load/store port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic [LAT_W-1:0]  lat_cnt;
  logic [STV_W-1:0]  starve_cnt;
  logic              acc_we;
  logic              grant_fetch;
  logic              grant_data;
  logic              lat_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Data normally wins (older instruction); a starved fetch overrides it.
  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    lat_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (if_req && (!d_req || (starve_cnt == STARVE_TOP))) begin
          grant_fetch = 1'b1;
          state_nxt   = S_ACCESS;
        end else if (d_req) begin
          grant_data = 1'b1;
          state_nxt  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (lat_cnt == LAT_LAST) begin
          lat_done  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      acc_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      mem_en   <= grant_fetch | grant_data;
      mem_we   <= grant_data & d_we;
      if_ready <= lat_done && (owner == OWN_FETCH);
      d_ready  <= lat_done && (owner == OWN_DATA);

      if (grant_fetch) begin
        owner      <= OWN_FETCH;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        acc_we     <= 1'b0;
        lat_cnt    <= '0;
        starve_cnt <= '0;
      end else if (grant_data) begin
        owner     <= OWN_DATA;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        acc_we    <= d_we;
        lat_cnt   <= '0;
        if (!if_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != STARVE_TOP) begin
          starve_cnt <= starve_cnt + STV_W'(1);
        end
      end

      if ((state == S_ACCESS) && !lat_done) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      // Stores leave d_rdata untouched so the last load value stays visible.
      if (lat_done) begin
        if (owner == OWN_FETCH) begin
          if_rdata <= mem_rdata;
        end else if ((owner == OWN_DATA) && !acc_we) begin
          d_rdata <= mem_rdata;
        end
      end

      if (state == S_RESP) begin
        owner <= OWN_NONE;
      end
    end
  end

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

`default_nettype wire
